// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the instruction sequencer
package seq_pkg;

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    STEP_RUN = 2'd2
  } seq_state_t;

  localparam logic [3:0] T0  = 4'd0;
  localparam logic [3:0] T1  = 4'd1;
  localparam logic [3:0] T2  = 4'd2;
  localparam logic [3:0] T3  = 4'd3;
  localparam logic [3:0] T4  = 4'd4;
  localparam logic [3:0] T5  = 4'd5;
  localparam logic [3:0] T6  = 4'd6;
  localparam logic [3:0] T7  = 4'd7;
  localparam logic [3:0] T8  = 4'd8;
  localparam logic [3:0] T9  = 4'd9;
  localparam logic [3:0] T10 = 4'd10;
  localparam logic [3:0] T11 = 4'd11;
  localparam logic [3:0] T12 = 4'd12;
  localparam logic [3:0] T13 = 4'd13;
  localparam logic [3:0] T14 = 4'd14;
  localparam logic [3:0] T15 = 4'd15;

  // Last time slot of each instruction class
  localparam logic [3:0] EOI_SLOT_R   = T2;
  localparam logic [3:0] EOI_SLOT_D7  = T3;
  localparam logic [3:0] EOI_SLOT_D34 = T4;
  localparam logic [3:0] EOI_SLOT_MEM = T5;
  localparam logic [3:0] EOI_SLOT_D6  = T6;

  localparam int IR_I   = 15;
  localparam int IR_HLT = 0;
  localparam int IR_ION = 7;
  localparam int IR_IOF = 6;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - control-unit side signals of the instruction sequencer
interface instr_sequencer_if;

  logic [15:0] IR;
  logic        START;
  logic        STEP;
  logic        FGI;
  logic        FGO;
  logic [15:0] TIME_SIGNAL;
  logic [7:0]  DEC_SIGNAL;
  logic        INDIRECT_BIT;
  logic        INTERRUPT_R;
  logic        IEN;
  logic        HALTED;
  logic        SC_ERROR;

  modport master (
    output IR, START, STEP, FGI, FGO,
    input  TIME_SIGNAL, DEC_SIGNAL, INDIRECT_BIT, INTERRUPT_R, IEN, HALTED, SC_ERROR
  );

  modport slave (
    input  IR, START, STEP, FGI, FGO,
    output TIME_SIGNAL, DEC_SIGNAL, INDIRECT_BIT, INTERRUPT_R, IEN, HALTED, SC_ERROR
  );

endinterface

// File: rtl/sc_decoder_4to16.sv
// rtl/sc_decoder_4to16.sv - sequence counter to one-hot time slot, gated off while halted
module sc_decoder_4to16 (
  input  logic [3:0]  sc,
  input  logic        en,
  output logic [15:0] t
);

  assign t = en ? (16'h0001 << sc) : 16'h0000;

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - SC, time/decode signals, halt/step control; interrupt logic under SEQ_INTERRUPT_EN
module instr_sequencer
  import seq_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  instr_sequencer_if.slave  bus
);

  seq_state_t  state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic        indirect_q;
  logic        sc_error_q;
  logic        r_q, ien_q, r_eoi;
  logic [7:0]  dec;
  logic [15:0] time_sig;
  logic        running, eoi_instr, eoi, hlt, watchdog;
  logic        unused_ir;

  assign dec     = 8'd1 << bus.IR[14:12];
  assign running = (state_q != HALT);

  sc_decoder_4to16 u_sc_dec (
    .sc (sc_q),
    .en (running),
    .t  (time_sig)
  );

  // Instruction EOI is not gated by R: a pending interrupt lets the current instruction finish.
  always_comb begin
    eoi_instr = 1'b0;
    hlt       = 1'b0;
    if (running) begin
      case (sc_q)
        EOI_SLOT_D7: begin
          eoi_instr = dec[7];
          hlt       = dec[7] && !bus.IR[IR_I] && bus.IR[IR_HLT] && !r_q;
        end
        EOI_SLOT_D34: eoi_instr = dec[3] || dec[4];
        EOI_SLOT_MEM: eoi_instr = dec[0] || dec[1] || dec[2] || dec[5];
        EOI_SLOT_D6:  eoi_instr = dec[6];
        default:      eoi_instr = 1'b0;
      endcase
    end
  end

  assign eoi      = eoi_instr || r_eoi;
  assign watchdog = running && (sc_q == T15) && !eoi;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    case (state_q)
      HALT: begin
        sc_d = T0;
        if (bus.START)     state_d = RUN;
        else if (bus.STEP) state_d = STEP_RUN;
      end
      RUN: begin
        sc_d = (eoi || watchdog) ? T0 : sc_q + 4'd1;
        if (hlt) state_d = HALT;
      end
      STEP_RUN: begin
        sc_d = (eoi || watchdog) ? T0 : sc_q + 4'd1;
        if (eoi) state_d = HALT;
      end
      default: begin
        state_d = HALT;
        sc_d    = T0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= HALT;
      sc_q       <= T0;
      indirect_q <= 1'b0;
      sc_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      if (running && !r_q && (sc_q == T2)) indirect_q <= bus.IR[IR_I];
      if (watchdog) sc_error_q <= 1'b1;
    end
  end

`ifdef SEQ_INTERRUPT_EN
  logic ion, iof, r_set;

  assign r_eoi = running && r_q && (sc_q == EOI_SLOT_R);
  assign ion   = running && dec[7] && bus.IR[IR_I] && bus.IR[IR_ION] && (sc_q == T3);
  assign iof   = running && dec[7] && bus.IR[IR_I] && bus.IR[IR_IOF] && (sc_q == T3);
  // HLT and IOF both suppress an interrupt request raised in the same slot.
  assign r_set = running && (sc_q > T2) && ien_q && (bus.FGI || bus.FGO) && !hlt && !iof;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q   <= 1'b0;
      ien_q <= 1'b0;
    end else if (r_eoi) begin
      r_q   <= 1'b0;
      ien_q <= 1'b0;
    end else begin
      if (r_set) r_q <= 1'b1;
      if (iof)      ien_q <= 1'b0;
      else if (ion) ien_q <= 1'b1;
    end
  end
`else
  logic unused_int;

  assign r_q        = 1'b0;
  assign ien_q      = 1'b0;
  assign r_eoi      = 1'b0;
  assign unused_int = bus.FGI ^ bus.FGO ^ bus.IR[IR_ION] ^ bus.IR[IR_IOF];
`endif

  assign unused_ir = ^{bus.IR[11:8], bus.IR[5:1]};

  assign bus.TIME_SIGNAL  = time_sig;
  assign bus.DEC_SIGNAL   = dec;
  assign bus.INDIRECT_BIT = indirect_q;
  assign bus.INTERRUPT_R  = r_q;
  assign bus.IEN          = ien_q;
  assign bus.HALTED       = (state_q == HALT);
  assign bus.SC_ERROR     = sc_error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

  typedef struct {
    logic [15:0] time_sig;
    logic        halted;
    logic        r;
  } exp_t;

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  dec;
    int          slot;
    logic        ind;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[9];

  always #5 CLK = ~CLK;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_t(input int slot, input logic r);
    exp_t e;
    e.time_sig = 16'h0001 << slot;
    e.halted   = 1'b0;
    e.r        = r;
    sb.push_back(e);
  endtask

  task automatic push_halt();
    exp_t e;
    e.time_sig = 16'h0000;
    e.halted   = 1'b1;
    e.r        = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty", name);
      end else begin
        e = sb.pop_front();
        check({name, " time"}, bus.TIME_SIGNAL, e.time_sig);
        check({name, " halted"}, bus.HALTED, e.halted);
        check({name, " r"}, bus.INTERRUPT_R, e.r);
      end
      tick();
    end
  endtask

  task automatic drain_all(input string name);
    drain(name, sb.size());
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic pulse_step();
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0123, 8'h01, 5, 1'b0};
    vecs[1] = '{16'h9123, 8'h02, 5, 1'b1};
    vecs[2] = '{16'h2456, 8'h04, 5, 1'b0};
    vecs[3] = '{16'hB456, 8'h08, 4, 1'b1};
    vecs[4] = '{16'h4000, 8'h10, 4, 1'b0};
    vecs[5] = '{16'hD000, 8'h20, 5, 1'b1};
    vecs[6] = '{16'h6000, 8'h40, 6, 1'b0};
    vecs[7] = '{16'h7800, 8'h80, 3, 1'b0};
    vecs[8] = '{16'hF800, 8'h80, 3, 1'b1};

    bus.IR = 16'h0000; bus.START = 1'b0; bus.STEP = 1'b0;
    bus.FGI = 1'b0; bus.FGO = 1'b0;
    do_reset();
    check("rst time", bus.TIME_SIGNAL, 16'h0000);
    check("rst halted", bus.HALTED, 1'b1);
    check("rst ind", bus.INDIRECT_BIT, 1'b0);
    check("rst r", bus.INTERRUPT_R, 1'b0);
    check("rst ien", bus.IEN, 1'b0);
    check("rst err", bus.SC_ERROR, 1'b0);
    check("rst dec", bus.DEC_SIGNAL, 8'h01);

    // Each instruction class single-stepped: EOI slot, decode and indirect latch
    for (int i = 0; i < 9; i++) begin
      bus.IR = vecs[i].ir;
      #1;
      check("table dec", bus.DEC_SIGNAL, vecs[i].dec);
      pulse_step();
      for (int s = 0; s <= vecs[i].slot; s++) push_t(s, 1'b0);
      push_halt();
      drain_all("table");
      check("table ind", bus.INDIRECT_BIT, vecs[i].ind);
    end

    // START with LDA, START ignored mid-run, then HLT
    bus.IR = 16'h2000;
    pulse_start();
    for (int s = 0; s <= 5; s++) push_t(s, 1'b0);
    push_t(0, 1'b0);
    drain("lda", 2);
    bus.START = 1'b1;
    drain("lda", 1);
    bus.START = 1'b0;
    drain_all("lda");
    bus.IR = 16'h7001;
    for (int s = 1; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    push_halt();
    drain_all("hlt");
    pulse_step();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    push_halt();
    drain_all("hlt step");

    // START beats STEP: sequencer keeps running past the first EOI
    bus.IR = 16'h2000;
    bus.START = 1'b1;
    bus.STEP = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.STEP = 1'b0;
    for (int s = 0; s <= 5; s++) push_t(s, 1'b0);
    push_t(0, 1'b0);
    drain_all("prio");
    bus.IR = 16'h7001;
    for (int s = 1; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("prio hlt");

    // Reset in the middle of ISZ
    bus.IR = 16'h6000;
    pulse_start();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    drain_all("isz");
    check("isz t4", bus.TIME_SIGNAL, 16'h0010);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("isz rst time", bus.TIME_SIGNAL, 16'h0000);
    check("isz rst halted", bus.HALTED, 1'b1);
    check("isz rst err", bus.SC_ERROR, 1'b0);

    // Watchdog: IR turns into a D7 after T3, so no EOI ever matches
    bus.IR = 16'h2000;
    pulse_start();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    drain_all("wd");
    bus.IR = 16'h7000;
    for (int s = 4; s <= 15; s++) push_t(s, 1'b0);
    drain("wd", 11);
    check("wd err before wrap", bus.SC_ERROR, 1'b0);
    drain_all("wd");
    check("wd wrap time", bus.TIME_SIGNAL, 16'h0001);
    check("wd err set", bus.SC_ERROR, 1'b1);
    bus.IR = 16'h7001;
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("wd hlt");
    check("wd err sticky", bus.SC_ERROR, 1'b1);
    do_reset();
    check("wd err cleared", bus.SC_ERROR, 1'b0);

`ifdef SEQ_INTERRUPT_EN
    // ION, then an interrupt request during T4 of an LDA
    bus.IR = 16'hF080;
    pulse_step();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("ion");
    check("ion ien", bus.IEN, 1'b1);
    bus.IR = 16'h2000;
    pulse_start();
    for (int s = 0; s <= 4; s++) push_t(s, 1'b0);
    push_t(5, 1'b1);
    for (int s = 0; s <= 2; s++) push_t(s, 1'b1);
    push_t(0, 1'b0);
    drain("irq", 4);
    bus.FGI = 1'b1;
    drain("irq", 3);
    bus.IR = 16'hA000;
    drain_all("irq");
    check("irq ien cleared", bus.IEN, 1'b0);
    check("irq r cleared", bus.INTERRUPT_R, 1'b0);
    check("irq ind untouched", bus.INDIRECT_BIT, 1'b0);
    bus.IR = 16'h7001;
    for (int s = 1; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("irq hlt");

    // IOF with a request pending: R must never set
    bus.IR = 16'hF080;
    pulse_step();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("ion2");
    check("ion2 ien", bus.IEN, 1'b1);
    bus.IR = 16'hF040;
    pulse_step();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    push_halt();
    drain_all("iof");
    check("iof ien", bus.IEN, 1'b0);
    check("iof r", bus.INTERRUPT_R, 1'b0);

    // HLT with a request pending: R must stay clear
    bus.IR = 16'hF080;
    pulse_step();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("ion3");
    bus.IR = 16'h7001;
    pulse_step();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    push_halt();
    drain_all("hlt vs r");
    check("hlt vs r ien", bus.IEN, 1'b1);
    check("hlt vs r r", bus.INTERRUPT_R, 1'b0);
`else
    // Without interrupts ION has no effect and flags are ignored
    bus.FGI = 1'b1;
    bus.FGO = 1'b1;
    bus.IR = 16'hF080;
    pulse_step();
    for (int s = 0; s <= 3; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("noint ion");
    check("noint ien", bus.IEN, 1'b0);
    bus.IR = 16'h2000;
    pulse_step();
    for (int s = 0; s <= 5; s++) push_t(s, 1'b0);
    push_halt();
    drain_all("noint lda");
    check("noint r", bus.INTERRUPT_R, 1'b0);
    check("noint ien2", bus.IEN, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
